// File: rtl/game_turn_ctrl_if.sv
// Handshake bundle between the 2048 turn controller and its sub-blocks.
// master: controller side; slave: player input, engines, checker, board.
interface game_turn_ctrl_if;
    logic        new_game;
    logic        dir_valid;
    logic [1:0]  dir;
    logic        dir_ready;
    logic        move_start;
    logic [1:0]  move_dir;
    logic        move_done;
    logic        move_changed;
    logic        place_start;
    logic        place_done;
    logic        check_start;
    logic        check_done;
    logic        check_win;
    logic        check_lose;
    logic        board_clear;
    logic        board_load;
    logic        board_src;
    logic        busy;
    logic        game_won;
    logic        game_over;
    logic        err_timeout;
    logic [15:0] turn_count;

    modport master (
        input  new_game, dir_valid, dir,
        input  move_done, move_changed,
        input  place_done,
        input  check_done, check_win, check_lose,
        output dir_ready, move_start, move_dir,
        output place_start, check_start,
        output board_clear, board_load, board_src,
        output busy, game_won, game_over,
        output err_timeout, turn_count
    );

    modport slave (
        output new_game, dir_valid, dir,
        output move_done, move_changed,
        output place_done,
        output check_done, check_win, check_lose,
        input  dir_ready, move_start, move_dir,
        input  place_start, check_start,
        input  board_clear, board_load, board_src,
        input  busy, game_won, game_over,
        input  err_timeout, turn_count
    );
endinterface

// File: rtl/game_turn_ctrl.sv
// 2048 turn sequencer: clear/init board, move, place, check, score turns.
// Ports: clk, rst (async active-low), bus (game_turn_ctrl_if.master).
module game_turn_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic            clk,
    input logic            rst,
    game_turn_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        WAIT_NEW, CLEAR, INIT0, INIT1, IDLE,
        MOVE, PLACE, CHECK, WON, LOST
    } state_t;

    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        timed_out;

    // wait_cnt equals the cycle offset from the start pulse, so the
    // last cycle a done is still accepted is TIMEOUT_CYC-1.
    assign timed_out = (wait_cnt == LAST_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= WAIT_NEW;
            wait_cnt        <= '0;
            bus.dir_ready   <= 1'b0;
            bus.move_start  <= 1'b0;
            bus.move_dir    <= 2'b00;
            bus.place_start <= 1'b0;
            bus.check_start <= 1'b0;
            bus.board_clear <= 1'b0;
            bus.board_load  <= 1'b0;
            bus.board_src   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.game_won    <= 1'b0;
            bus.game_over   <= 1'b0;
            bus.err_timeout <= 1'b0;
            bus.turn_count  <= '0;
        end else begin
            bus.move_start  <= 1'b0;
            bus.place_start <= 1'b0;
            bus.check_start <= 1'b0;
            bus.board_clear <= 1'b0;
            bus.board_load  <= 1'b0;
            if (bus.new_game) begin
                state           <= CLEAR;
                wait_cnt        <= '0;
                bus.board_clear <= 1'b1;
                bus.board_src   <= 1'b0;
                bus.dir_ready   <= 1'b0;
                bus.busy        <= 1'b1;
                bus.game_won    <= 1'b0;
                bus.game_over   <= 1'b0;
                bus.err_timeout <= 1'b0;
                bus.turn_count  <= '0;
            end else begin
                unique case (state)
                    WAIT_NEW, WON, LOST: begin
                    end
                    CLEAR: begin
                        state           <= INIT0;
                        bus.place_start <= 1'b1;
                        wait_cnt        <= '0;
                    end
                    // Each placer state: start cycle, wait, one load
                    // cycle; the load cycle itself marks "done seen".
                    INIT0, INIT1, PLACE: begin
                        if (bus.place_start) begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end else if (bus.board_load) begin
                            if (state == INIT0) begin
                                state           <= INIT1;
                                bus.place_start <= 1'b1;
                                wait_cnt        <= '0;
                            end else if (state == INIT1) begin
                                state         <= IDLE;
                                bus.dir_ready <= 1'b1;
                                bus.busy      <= 1'b0;
                            end else begin
                                state           <= CHECK;
                                bus.check_start <= 1'b1;
                                wait_cnt        <= '0;
                            end
                        end else if (bus.place_done) begin
                            bus.board_load <= 1'b1;
                            bus.board_src  <= 1'b1;
                        end else if (timed_out) begin
                            state           <= LOST;
                            bus.err_timeout <= 1'b1;
                            bus.game_over   <= 1'b1;
                            bus.busy        <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                    IDLE: begin
                        if (bus.dir_valid) begin
                            state          <= MOVE;
                            bus.move_dir   <= bus.dir;
                            bus.move_start <= 1'b1;
                            bus.dir_ready  <= 1'b0;
                            bus.busy       <= 1'b1;
                            wait_cnt       <= '0;
                        end
                    end
                    MOVE: begin
                        if (bus.move_start) begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end else if (bus.board_load) begin
                            state           <= PLACE;
                            bus.place_start <= 1'b1;
                            wait_cnt        <= '0;
                        end else if (bus.move_done) begin
                            if (bus.move_changed) begin
                                bus.board_load <= 1'b1;
                                bus.board_src  <= 1'b0;
                            end else begin
                                state         <= IDLE;
                                bus.dir_ready <= 1'b1;
                                bus.busy      <= 1'b0;
                            end
                        end else if (timed_out) begin
                            state           <= LOST;
                            bus.err_timeout <= 1'b1;
                            bus.game_over   <= 1'b1;
                            bus.busy        <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                    CHECK: begin
                        if (bus.check_start) begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end else if (bus.check_done) begin
                            bus.busy <= 1'b0;
                            if (bus.check_win) begin
                                state        <= WON;
                                bus.game_won <= 1'b1;
                            end else if (bus.check_lose) begin
                                state         <= LOST;
                                bus.game_over <= 1'b1;
                            end else begin
                                state         <= IDLE;
                                bus.dir_ready <= 1'b1;
                                if (bus.turn_count != 16'hFFFF) begin
                                    bus.turn_count <=
                                        bus.turn_count + 16'd1;
                                end
                            end
                        end else if (timed_out) begin
                            state           <= LOST;
                            bus.err_timeout <= 1'b1;
                            bus.game_over   <= 1'b1;
                            bus.busy        <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= WAIT_NEW;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_game_turn_ctrl.sv
// Randomized turn-level bench for game_turn_ctrl.
// Ports driven through game_turn_ctrl_if; TIMEOUT_CYC fixed at 8.
module tb_game_turn_ctrl;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_tc = 0;
    int   g_end = 0;

    game_turn_ctrl_if bus();

    game_turn_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            n_cmp++;
            assert ($onehot0({bus.move_start, bus.place_start,
                              bus.check_start, bus.board_clear,
                              bus.board_load})) else begin
                n_bad++;
                $error("FAIL pulse_mutex observed=%b expected=onehot0",
                       {bus.move_start, bus.place_start,
                        bus.check_start, bus.board_clear,
                        bus.board_load});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pulse_of(input int w);
        case (w)
            0:       return bus.move_start;
            1:       return bus.place_start;
            2:       return bus.check_start;
            3:       return bus.board_clear;
            default: return bus.board_load;
        endcase
    endfunction

    task automatic set_done(input int w, input logic v);
        case (w)
            0:       bus.move_done = v;
            1:       bus.place_done = v;
            default: bus.check_done = v;
        endcase
    endtask

    function automatic logic [31:0] all_out();
        return 32'({bus.dir_ready, bus.move_start, bus.move_dir,
                    bus.place_start, bus.check_start,
                    bus.board_clear, bus.board_load, bus.board_src,
                    bus.busy, bus.game_won, bus.game_over,
                    bus.err_timeout, bus.turn_count});
    endfunction

    task automatic wait_pulse(input int w, input string tag);
        int n = 0;
        while (pulse_of(w) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(pulse_of(w)), 1);
    endtask

    // Start pulse at offset 0, done offered at offset d, optional
    // stray done on the start cycle which must be ignored.
    task automatic respond(input int w, input int d, input bit spur,
                           input string tag);
        wait_pulse(w, {tag, "_start"});
        if (spur) set_done(w, 1'b1);
        tick();
        set_done(w, 1'b0);
        chk({tag, "_1cyc"}, 32'(pulse_of(w)), 0);
        for (int k = 1; k < d; k++) begin
            chk({tag, "_wait_load"}, 32'(bus.board_load), 0);
            chk({tag, "_wait_busy"}, 32'(bus.busy), 1);
            tick();
        end
        chk({tag, "_pre_load"}, 32'(bus.board_load), 0);
        set_done(w, 1'b1);
        tick();
        set_done(w, 1'b0);
    endtask

    task automatic place_step(input string tag);
        respond(1, $urandom_range(1, T - 1), 1'($urandom_range(0, 1)),
                tag);
        chk({tag, "_load"}, 32'(bus.board_load), 1);
        chk({tag, "_src"}, 32'(bus.board_src), 1);
    endtask

    task automatic new_game();
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        exp_tc = 0;
        g_end = 0;
        chk("ng_clear", 32'(bus.board_clear), 1);
        chk("ng_tc", 32'(bus.turn_count), 0);
        chk("ng_flags", 32'({bus.game_won, bus.game_over,
                             bus.err_timeout}), 0);
        chk("ng_busy", 32'(bus.busy), 1);
        tick();
        chk("clear_1cyc", 32'(bus.board_clear), 0);
        place_step("init0");
        place_step("init1");
        tick();
        chk("init_idle_rdy", 32'(bus.dir_ready), 1);
        chk("init_idle_busy", 32'(bus.busy), 0);
        chk("init_tc", 32'(bus.turn_count), 0);
    endtask

    task automatic do_turn(input logic [1:0] dr, input bit chg,
                           input bit win, input bit lose,
                           input int dm, input bit spur);
        chk("turn_rdy", 32'(bus.dir_ready), 1);
        bus.dir_valid = 1'b1;
        bus.dir = dr;
        bus.move_done = 1'($urandom_range(0, 1));
        tick();
        bus.move_done = 1'b0;
        chk("mv_start", 32'(bus.move_start), 1);
        chk("mv_dir", 32'(bus.move_dir), 32'(dr));
        chk("mv_rdy", 32'(bus.dir_ready), 0);
        bus.dir = ~dr;
        bus.move_changed = chg;
        respond(0, dm, spur, "move");
        bus.dir_valid = 1'b0;
        chk("mv_dir_hold", 32'(bus.move_dir), 32'(dr));
        if (!chg) begin
            chk("nochg_load", 32'(bus.board_load), 0);
            chk("nochg_rdy", 32'(bus.dir_ready), 1);
            chk("nochg_tc", 32'(bus.turn_count), 32'(exp_tc));
            tick();
            chk("nochg_place", 32'(bus.place_start), 0);
            return;
        end
        chk("mv_load", 32'(bus.board_load), 1);
        chk("mv_src", 32'(bus.board_src), 0);
        place_step("place");
        bus.check_win = win;
        bus.check_lose = lose;
        respond(2, $urandom_range(1, T - 1), 1'($urandom_range(0, 1)),
                "check");
        bus.check_win = 1'b0;
        bus.check_lose = 1'b0;
        if (win) g_end = 1;
        else if (lose) g_end = 2;
        else if (exp_tc < 65535) exp_tc++;
        chk("ck_won", 32'(bus.game_won), 32'(g_end == 1));
        chk("ck_over", 32'(bus.game_over), 32'(g_end == 2));
        chk("ck_tc", 32'(bus.turn_count), 32'(exp_tc));
        chk("ck_rdy", 32'(bus.dir_ready), 32'(g_end == 0));
        chk("ck_busy", 32'(bus.busy), 0);
        chk("ck_err", 32'(bus.err_timeout), 0);
    endtask

    task automatic end_hold(input string tag);
        bus.dir_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk({tag, "_nomove"}, 32'(bus.move_start), 0);
            chk({tag, "_rdy"}, 32'(bus.dir_ready), 0);
        end
        bus.dir_valid = 1'b0;
        chk({tag, "_won"}, 32'(bus.game_won), 32'(g_end == 1));
        chk({tag, "_over"}, 32'(bus.game_over), 32'(g_end == 2));
    endtask

    initial begin
        bus.new_game = 1'b0;
        bus.dir_valid = 1'b0;
        bus.dir = 2'b00;
        bus.move_done = 1'b0;
        bus.move_changed = 1'b0;
        bus.place_done = 1'b0;
        bus.check_done = 1'b0;
        bus.check_win = 1'b0;
        bus.check_lose = 1'b0;
        #1;
        chk("rst_outs", all_out(), 0);
        tick();
        tick();
        rst = 1'b1;
        bus.dir_valid = 1'b1;
        tick();
        chk("wait_new_outs", all_out(), 0);
        tick();
        chk("wait_new_dir", all_out(), 0);
        bus.dir_valid = 1'b0;

        new_game();
        do_turn(2'b10, 1'b1, 1'b0, 1'b0, 3, 1'b1);
        chk("d020_tc", 32'(bus.turn_count), 1);
        do_turn(2'b01, 1'b0, 1'b0, 1'b0, T - 1, 1'b1);
        do_turn(2'b11, 1'b1, 1'b0, 1'b0, T - 1, 1'b0);
        chk("d_edge_tc", 32'(bus.turn_count), 2);
        do_turn(2'b00, 1'b1, 1'b1, 1'b1, 2, 1'b0);
        end_hold("won");

        for (int g = 0; g < 5; g++) begin
            new_game();
            for (int t = 0; t < 10 && g_end == 0; t++) begin
                do_turn(2'($urandom_range(0, 3)),
                        $urandom_range(0, 9) < 7,
                        $urandom_range(0, 14) == 0,
                        $urandom_range(0, 9) == 0,
                        $urandom_range(1, T - 1),
                        1'($urandom_range(0, 1)));
            end
            if (g_end != 0) end_hold("rnd_end");
        end

        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        tick();
        wait_pulse(1, "to_start");
        for (int k = 1; k < T; k++) begin
            tick();
            chk("to_pending", 32'(bus.err_timeout), 0);
        end
        tick();
        chk("to_err", 32'(bus.err_timeout), 1);
        chk("to_over", 32'(bus.game_over), 1);
        chk("to_busy", 32'(bus.busy), 0);
        g_end = 2;
        end_hold("to_hold");
        new_game();
        chk("to_clr", 32'({bus.err_timeout, bus.game_over}), 0);

        bus.dir_valid = 1'b1;
        bus.dir = 2'b01;
        tick();
        bus.dir_valid = 1'b0;
        tick();
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        chk("mid_ng_clear", 32'(bus.board_clear), 1);
        bus.move_done = 1'b1;
        bus.move_changed = 1'b1;
        tick();
        bus.move_done = 1'b0;
        chk("mid_ng_init", 32'(bus.place_start), 1);
        chk("mid_ng_noload", 32'(bus.board_load), 0);
        place_step("mid_init0");
        place_step("mid_init1");
        tick();
        chk("mid_ng_idle", 32'(bus.dir_ready), 1);

        bus.dir_valid = 1'b1;
        bus.dir = 2'b11;
        tick();
        bus.dir_valid = 1'b0;
        bus.move_changed = 1'b1;
        respond(0, 2, 1'b0, "rst_move");
        chk("rst_mv_load", 32'(bus.board_load), 1);
        wait_pulse(1, "rst_place");
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async", all_out(), 0);
        #2;
        rst = 1'b1;
        tick();
        bus.place_done = 1'b1;
        tick();
        bus.place_done = 1'b0;
        chk("rst_late_done", all_out(), 0);
        tick();
        chk("rst_wait_new", all_out(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/game_turn_ctrl.md
GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, max wait cycles for any sub-block done (range 2..65535).
REQ-002 SHALL have ports:
  clk  in  1  system clock, rising edge
  rst  in  1  reset, asynchronous, active-low
  new_game  in  1  start/restart game pulse
  dir_valid  in  1  player direction request
  dir  in  2  00 up, 01 down, 10 left, 11 right
  dir_ready  out  1  controller accepts direction
  move_start  out  1  one-cycle start to move/merge engine
  move_dir  out  2  latched direction, stable from move_start to move_done
  move_done  in  1  move engine finished
  move_changed  in  1  board changed; valid only with move_done
  place_start  out  1  one-cycle start to random tile placer
  place_done  in  1  tile placed
  check_start  out  1  one-cycle start to win/lose checker
  check_done  in  1  check finished
  check_win  in  1  2048 tile present; valid with check_done
  check_lose  in  1  no legal move; valid with check_done
  board_clear  out  1  one-cycle pulse zeroing game board register
  board_load  out  1  one-cycle pulse committing selected result into board register
  board_src  out  1  0 = move result, 1 = placer result; valid with board_load
  busy  out  1  high in every state except IDLE, WAIT_NEW, WON, LOST
  game_won  out  1  sticky win flag
  game_over  out  1  sticky loss flag
  err_timeout  out  1  sticky timeout flag
  turn_count  out  16  completed changing turns, saturating

Function
REQ-003 All outputs SHALL be registered.
REQ-004 States: WAIT_NEW, CLEAR, INIT0, INIT1, IDLE, MOVE, PLACE, CHECK, WON, LOST.
REQ-005 WAIT_NEW SHALL hold with all outputs 0 until new_game.
REQ-006 new_game SHALL take priority in every state: next state CLEAR; game_won, game_over, err_timeout, turn_count cleared the same edge; in-flight sub-block results discarded.
REQ-007 CLEAR SHALL assert board_clear for exactly one cycle, then enter INIT0.
REQ-008 INIT0 and INIT1 SHALL each pulse place_start on the first cycle in the state, wait for place_done, pulse board_load with board_src=1 the cycle after place_done; INIT0 -> INIT1 -> IDLE.
REQ-009 IDLE SHALL drive dir_ready=1; dir_valid sampled high latches dir into move_dir and enters MOVE; dir_valid while dir_ready=0 SHALL be ignored, not queued.
REQ-010 MOVE SHALL pulse move_start on entry and wait for move_done; move_changed=1 -> board_load, board_src=0 next cycle, then PLACE; move_changed=0 -> IDLE, no board_load, turn_count unchanged.
REQ-011 PLACE SHALL behave as INIT0 (place_start, wait, board_load src=1), then CHECK.
REQ-012 CHECK SHALL pulse check_start on entry and wait for check_done: check_win=1 -> WON (priority over lose); else check_lose=1 -> LOST; else turn_count+1 (saturate at 16'hFFFF), then IDLE.
REQ-013 WON SHALL hold game_won=1, LOST SHALL hold game_over=1, until new_game.
REQ-014 Done inputs SHALL be ignored outside the state awaiting them, including on the start-pulse cycle.
REQ-015 Wait counter SHALL reset on entry to INIT0, INIT1, MOVE, PLACE, CHECK; if TIMEOUT_CYC cycles elapse after the start pulse without the awaited done, set err_timeout=1 and game_over=1, enter LOST.
REQ-016 At most one of move_start, place_start, check_start, board_clear, board_load SHALL be high in any cycle.

Reset
REQ-017 rst low SHALL immediately force WAIT_NEW, all outputs 0, move_dir=00, wait counter 0, independent of clk.
REQ-018 Reset release SHALL take effect on the first rising clk edge with rst high; reset mid-turn SHALL discard the turn.

Verification
REQ-019 new_game pulse, placer done after 3 cycles each -> board_clear 1 cycle, two place_start/board_load(src=1) pairs, IDLE, dir_ready=1, turn_count=0.
REQ-020 IDLE, dir=10, move_done with move_changed=1, place_done, check_done win=0 lose=0 -> move_dir=10, board_load src=0 then src=1, turn_count=1, back to IDLE.
REQ-021 move_done with move_changed=0 -> no place_start, no board_load, turn_count unchanged, dir_ready=1 next cycle.
REQ-022 check_done with check_win=1, check_lose=1 -> WON, game_won=1, game_over=0; dir_valid ignored until new_game.
REQ-023 place_done never asserted, TIMEOUT_CYC=8 -> err_timeout=1, game_over=1 after 8 cycles; new_game clears both.
REQ-024 rst low during PLACE, then release -> all outputs 0, WAIT_NEW; late place_done produces no board_load.
